microsequencer: RTL and testbench
=================================

// Module: microsequencer
// PURPOSE
//  Control-unit state sequencer. Consumes the 7-bit dispatch state produced by the instruction encoder.
//  Walks fetch/decode/execute microstates and drives the registered control word to the datapath.
//  Sits between the encoder (dispatch input), the memory (MOC handshake) and the condition tester.
// PARAMETERS
//  STATE_W      7    microstate width (matches encoder output)
//  CTRL_W       40   control word width
//  FETCH_STATE  1    target for NS_FETCH, failed condition and NOP dispatch
//  TIMEOUT_CYC  16   wait cycles before MOC timeout (macro-gated only)
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        synchronous, active-high
//  enc_state    in   STATE_W  dispatch state from encoder; sampled in ST_DECODE only
//  cond_pass    in   1        instruction condition true; sampled in ST_DECODE only
//  moc          in   1        memory operation complete; sampled in wait states only
//  state_out    out  STATE_W  current microstate
//  ctrl_word    out  CTRL_W   registered ROM control word for state_out
//  mem_req      out  1        high in every ROM state with wait=1
//  undef_pulse  out  1        one-cycle pulse on entering ST_UNDEF
//  timeout_err  out  1        sticky MOC timeout flag; 0 when macro absent
// BEHAVIOUR
//  - Reset: state_out=0, ctrl_word=0, mem_req=0, undef_pulse=0, timeout_err=0. Reset beats all inputs,
//    including mid-wait; mem_req low after the reset edge.
//  - Each ROM entry: ns_sel[1:0], wait, jmp[STATE_W-1:0], ctrl[CTRL_W-1:0].
//  - state_out and ctrl_word update on the same edge. ctrl_word <= ROM[next].ctrl, so it is always aligned with state_out.
//  - Next-state select:
//    NS_INC=state+1; 127 wraps to 0.
//    NS_JMP=jmp.
//    NS_FETCH=FETCH_STATE.
//    NS_DISP=enc_state if cond_pass, else FETCH_STATE. enc_state==0 (NOP word) also goes to FETCH_STATE.
//  - wait=1 and moc=0: hold state. wait=1 and moc=1: take ns_sel on the next edge.
//    Minimum one cycle in a wait state; moc outside a wait state is ignored.
//  - Fixed flow: ST_RESET(0) -> ST_FETCH(1) -> ST_FETCH_WAIT(2, wait) -> ST_DECODE(3, NS_DISP) -> execute chain.
//    Last execute state uses NS_FETCH.
//  - ST_UNDEF(91): undef_pulse=1 for its single cycle; NS_FETCH.
//  - Any undefined ROM address holds ctrl=0 and NS_FETCH.
//  - mem_req is registered alongside state_out (ROM[next].wait).
// CONFIGURATION
//  SEQ_MOC_TIMEOUT_EN defined:
//    - A counter clears on entry to a wait state and counts each cycle with moc=0.
//    - On reaching TIMEOUT_CYC: next state=ST_RESET, timeout_err<=1 (sticky until reset).
//    - moc arriving on the same cycle the count hits the limit wins: normal advance, no error.
//  SEQ_MOC_TIMEOUT_EN undefined:
//    - No counter; waits are indefinite.
//    - timeout_err tied 0; the port is present in both builds.
// STRUCTURE
//  Package arm_ctrl_pkg:
//    - STATE_W, CTRL_W
//    - ST_RESET/ST_FETCH/ST_FETCH_WAIT/ST_DECODE/ST_UNDEF constants
//    - ns_sel_t enum
//    - microword_t struct
//    - ROM contents as a constant function
//  Sub-module ctrl_rom: combinational microword lookup by address.
//  microsequencer holds the state register, next-state mux and wait/timeout logic.
// TESTING
//  1. reset 2 cycles, moc=0 -> state 0,0,1,2,2,2...; ctrl_word=0 during reset; mem_req=1 from state 2.
//  2. moc=1 one cycle in state 2, then enc_state=43, cond_pass=1 -> state 3 then 43;
//     ctrl_word==ROM[43].ctrl with state 43.
//  3. In state 3, cond_pass=0, enc_state=44 -> state 1.
//     Also enc_state=0, cond_pass=1 -> state 1.
//  4. enc_state=91 at decode -> state 91, undef_pulse=1 exactly one cycle, then state 1.
//  5. reset asserted while in state 2 with mem_req=1 -> next edge state 0, mem_req=0.
//  6. Macro on, moc=0 for 16 cycles in state 2 -> state 0, timeout_err=1 and held.
//     Same cycle with moc=1 at count 16 -> state 3, timeout_err=0.
//     Macro off -> state 2 held indefinitely.

Source files
------------

// File: rtl/microsequencer_pkg.sv
// Shared microcode types, state constants and ROM contents for the control-unit sequencer.
package arm_ctrl_pkg;

    localparam int STATE_W = 7;
    localparam int CTRL_W  = 40;

    localparam logic [STATE_W-1:0] ST_RESET      = 7'd0;
    localparam logic [STATE_W-1:0] ST_FETCH      = 7'd1;
    localparam logic [STATE_W-1:0] ST_FETCH_WAIT = 7'd2;
    localparam logic [STATE_W-1:0] ST_DECODE     = 7'd3;
    localparam logic [STATE_W-1:0] ST_UNDEF      = 7'd91;

    typedef enum logic [1:0] {
        NS_INC   = 2'd0,
        NS_JMP   = 2'd1,
        NS_FETCH = 2'd2,
        NS_DISP  = 2'd3
    } ns_sel_t;

    typedef struct packed {
        ns_sel_t             ns_sel;
        logic                wait_st;
        logic [STATE_W-1:0]  jmp;
        logic [CTRL_W-1:0]   ctrl;
    } microword_t;

    function automatic microword_t mk_word(input ns_sel_t sel, input logic wt,
                                           input logic [STATE_W-1:0] jmp,
                                           input logic [CTRL_W-1:0] ctrl);
        microword_t w;
        w.ns_sel  = sel;
        w.wait_st = wt;
        w.jmp     = jmp;
        w.ctrl    = ctrl;
        return w;
    endfunction

    // Unlisted addresses fall back to an inert word that returns to fetch.
    function automatic microword_t rom_lookup(input logic [STATE_W-1:0] addr);
        microword_t w;
        w = mk_word(NS_FETCH, 1'b0, '0, '0);
        case (addr)
            7'd0:   w = mk_word(NS_INC,   1'b0, '0,    40'h00_0000_0000);
            7'd1:   w = mk_word(NS_INC,   1'b0, '0,    40'h00_0000_0011);
            7'd2:   w = mk_word(NS_INC,   1'b1, '0,    40'h00_0000_0120);
            7'd3:   w = mk_word(NS_DISP,  1'b0, '0,    40'h00_0000_1000);
            7'd16:  w = mk_word(NS_INC,   1'b0, '0,    40'h00_0001_0016);
            7'd17:  w = mk_word(NS_FETCH, 1'b0, '0,    40'h00_0002_0017);
            7'd32:  w = mk_word(NS_INC,   1'b0, '0,    40'h00_0010_0032);
            7'd33:  w = mk_word(NS_INC,   1'b1, '0,    40'h00_0020_0033);
            7'd34:  w = mk_word(NS_FETCH, 1'b0, '0,    40'h00_0040_0034);
            7'd43:  w = mk_word(NS_INC,   1'b0, '0,    40'hA5_0000_0043);
            7'd44:  w = mk_word(NS_INC,   1'b1, '0,    40'h00_0C00_0044);
            7'd45:  w = mk_word(NS_FETCH, 1'b0, '0,    40'h00_0000_0345);
            7'd48:  w = mk_word(NS_JMP,   1'b0, 7'd16, 40'h00_0100_0048);
            7'd91:  w = mk_word(NS_FETCH, 1'b0, '0,    40'h80_0000_0091);
            7'd127: w = mk_word(NS_INC,   1'b0, '0,    40'h00_0000_007F);
            default: ;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/microsequencer_ctrl_rom.sv
// Combinational microword lookup; contents live in arm_ctrl_pkg::rom_lookup.
module ctrl_rom
    import arm_ctrl_pkg::*;
(
    input  logic [STATE_W-1:0] addr,
    output microword_t         word
);

    assign word = rom_lookup(addr);

endmodule

// File: rtl/microsequencer.sv
// Microsequencer: state register, next-state mux and MOC wait handling.
// Optional MOC timeout watchdog enabled by defining SEQ_MOC_TIMEOUT_EN.
module microsequencer
    import arm_ctrl_pkg::*;
#(
    parameter logic [STATE_W-1:0] FETCH_STATE = 7'd1,
    parameter int                 TIMEOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] enc_state,
    input  logic               cond_pass,
    input  logic               moc,
    output logic [STATE_W-1:0] state_out,
    output logic [CTRL_W-1:0]  ctrl_word,
    output logic               mem_req,
    output logic               undef_pulse,
    output logic               timeout_err
);

    // The word for the current state is registered with the state, so its
    // ctrl, wait and sequencing fields are always aligned with state_out.
    logic [STATE_W-1:0] state_q, state_d, sel_state;
    microword_t         mw_q, mw_d;
    logic               undef_q, undef_d;
    logic               advance;
    logic               to_hit;

    ctrl_rom u_rom (
        .addr (state_d),
        .word (mw_d)
    );

    always_comb begin
        sel_state = FETCH_STATE;
        case (mw_q.ns_sel)
            NS_INC:   sel_state = state_q + 7'd1;
            NS_JMP:   sel_state = mw_q.jmp;
            NS_FETCH: sel_state = FETCH_STATE;
            NS_DISP:  sel_state = (cond_pass && (enc_state != '0)) ? enc_state : FETCH_STATE;
            default:  sel_state = FETCH_STATE;
        endcase
    end

    assign advance = !mw_q.wait_st || moc;

`ifdef SEQ_MOC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d;

    // moc on the final count wins over the timeout
    assign to_hit = mw_q.wait_st && !moc && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d  = cnt_q;
        terr_d = terr_q | to_hit;
        if (advance || to_hit) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            terr_q <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (to_hit) begin
            state_d = ST_RESET;
        end else if (advance) begin
            state_d = sel_state;
        end
        undef_d = (state_d == ST_UNDEF);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RESET;
            mw_q    <= '0;
            undef_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mw_q    <= mw_d;
            undef_q <= undef_d;
        end
    end

    assign state_out   = state_q;
    assign ctrl_word   = mw_q.ctrl;
    assign mem_req     = mw_q.wait_st;
    assign undef_pulse = undef_q;

endmodule

// File: tb/tb_microsequencer.sv
// Scoreboard bench for microsequencer: stimulus pushes expectations, a monitor pops per clock.
module tb_microsequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  enc_state = '0;
    logic        cond_pass = 1'b0;
    logic        moc = 1'b0;
    logic [6:0]  state_out;
    logic [39:0] ctrl_word;
    logic        mem_req;
    logic        undef_pulse;
    logic        timeout_err;

    always #5 clk = ~clk;

    microsequencer dut (
        .clk         (clk),
        .reset       (reset),
        .enc_state   (enc_state),
        .cond_pass   (cond_pass),
        .moc         (moc),
        .state_out   (state_out),
        .ctrl_word   (ctrl_word),
        .mem_req     (mem_req),
        .undef_pulse (undef_pulse),
        .timeout_err (timeout_err)
    );

    typedef struct {
        string       nm;
        logic [6:0]  st;
        logic [39:0] ctrl;
        logic        mr;
        logic        up;
        logic        te;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    logic te_exp = 1'b0;

    function automatic logic [39:0] ctrl_of(input logic [6:0] s);
        case (s)
            7'd1:    return 40'h00_0000_0011;
            7'd2:    return 40'h00_0000_0120;
            7'd3:    return 40'h00_0000_1000;
            7'd16:   return 40'h00_0001_0016;
            7'd17:   return 40'h00_0002_0017;
            7'd43:   return 40'hA5_0000_0043;
            7'd44:   return 40'h00_0C00_0044;
            7'd45:   return 40'h00_0000_0345;
            7'd48:   return 40'h00_0100_0048;
            7'd91:   return 40'h80_0000_0091;
            7'd127:  return 40'h00_0000_007F;
            default: return 40'h0;
        endcase
    endfunction

    task automatic step(input logic r, input logic m, input logic cp, input logic [6:0] es,
                        input logic [6:0] xs, input logic xm, input logic xu, input string nm);
        exp_t e;
        @(negedge clk);
        reset     = r;
        moc       = m;
        cond_pass = cp;
        enc_state = es;
        e.nm   = nm;
        e.st   = xs;
        e.ctrl = ctrl_of(xs);
        e.mr   = xm;
        e.up   = xu;
        e.te   = te_exp;
        q.push_back(e);
        @(posedge clk);
    endtask

    task automatic ck(input logic m, input logic cp, input logic [6:0] es,
                      input logic [6:0] xs, input logic xm, input logic xu, input string nm);
        step(1'b0, m, cp, es, xs, xm, xu, nm);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (state_out !== e.st || ctrl_word !== e.ctrl || mem_req !== e.mr ||
                undef_pulse !== e.up || timeout_err !== e.te) begin
                errors++;
                $display("FAIL %s: got st=%0d ctrl=%h mr=%b up=%b te=%b, want st=%0d ctrl=%h mr=%b up=%b te=%b",
                         e.nm, state_out, ctrl_word, mem_req, undef_pulse, timeout_err,
                         e.st, e.ctrl, e.mr, e.up, e.te);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset and fetch into the first wait
        step(1'b1, 1'b0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, "rst0");
        step(1'b1, 1'b0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, "rst1");
        ck(1'b0, 1'b0, 7'd0, 7'd1, 1'b0, 1'b0, "t1_fetch");
        ck(1'b0, 1'b0, 7'd0, 7'd2, 1'b1, 1'b0, "t1_fwait");
        ck(1'b0, 1'b0, 7'd0, 7'd2, 1'b1, 1'b0, "t1_hold_a");
        ck(1'b0, 1'b0, 7'd0, 7'd2, 1'b1, 1'b0, "t1_hold_b");
        // dispatch into execute chain 43-45
        ck(1'b1, 1'b0, 7'd0, 7'd3, 1'b0, 1'b0, "t2_decode");
        ck(1'b0, 1'b1, 7'd43, 7'd43, 1'b0, 1'b0, "t2_exec43");
        ck(1'b1, 1'b0, 7'd0, 7'd44, 1'b1, 1'b0, "t2_exec44_moc_ignored");
        ck(1'b0, 1'b0, 7'd0, 7'd44, 1'b1, 1'b0, "t2_exec44_hold");
        ck(1'b1, 1'b0, 7'd0, 7'd45, 1'b0, 1'b0, "t2_exec45");
        ck(1'b0, 1'b0, 7'd0, 7'd1, 1'b0, 1'b0, "t2_back_fetch");
        ck(1'b0, 1'b0, 7'd0, 7'd2, 1'b1, 1'b0, "t2_fwait");
        ck(1'b1, 1'b0, 7'd0, 7'd3, 1'b0, 1'b0, "t3_decode_a");
        // failed condition and NOP dispatch
        ck(1'b0, 1'b0, 7'd44, 7'd1, 1'b0, 1'b0, "t3_condfail");
        ck(1'b0, 1'b0, 7'd0, 7'd2, 1'b1, 1'b0, "t3_fwait_a");
        ck(1'b1, 1'b0, 7'd0, 7'd3, 1'b0, 1'b0, "t3_decode_b");
        ck(1'b0, 1'b1, 7'd0, 7'd1, 1'b0, 1'b0, "t3_nop");
        ck(1'b0, 1'b0, 7'd0, 7'd2, 1'b1, 1'b0, "t3_fwait_b");
        ck(1'b1, 1'b0, 7'd0, 7'd3, 1'b0, 1'b0, "t4_decode");
        // undefined instruction
        ck(1'b0, 1'b1, 7'd91, 7'd91, 1'b0, 1'b1, "t4_undef");
        ck(1'b0, 1'b1, 7'd91, 7'd1, 1'b0, 1'b0, "t4_after_undef");
        ck(1'b0, 1'b0, 7'd0, 7'd2, 1'b1, 1'b0, "t4_fwait");
        ck(1'b1, 1'b0, 7'd0, 7'd3, 1'b0, 1'b0, "jmp_decode");
        // jump and wrap sequencing
        ck(1'b0, 1'b1, 7'd48, 7'd48, 1'b0, 1'b0, "jmp_48");
        ck(1'b0, 1'b0, 7'd0, 7'd16, 1'b0, 1'b0, "jmp_to_16");
        ck(1'b0, 1'b0, 7'd0, 7'd17, 1'b0, 1'b0, "jmp_17");
        ck(1'b0, 1'b0, 7'd0, 7'd1, 1'b0, 1'b0, "jmp_fetch");
        ck(1'b0, 1'b0, 7'd0, 7'd2, 1'b1, 1'b0, "wrap_fwait");
        ck(1'b1, 1'b0, 7'd0, 7'd3, 1'b0, 1'b0, "wrap_decode");
        ck(1'b0, 1'b1, 7'd127, 7'd127, 1'b0, 1'b0, "wrap_127");
        ck(1'b0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, "wrap_to_0");
        ck(1'b0, 1'b0, 7'd0, 7'd1, 1'b0, 1'b0, "wrap_fetch");
        ck(1'b0, 1'b0, 7'd0, 7'd2, 1'b1, 1'b0, "t5_fwait");
        // reset mid-wait beats moc
        step(1'b1, 1'b1, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, "t5_reset_midwait");
        ck(1'b0, 1'b0, 7'd0, 7'd1, 1'b0, 1'b0, "t5_fetch");
        ck(1'b0, 1'b0, 7'd0, 7'd2, 1'b1, 1'b0, "t6_fwait");
`ifdef SEQ_MOC_TIMEOUT_EN
        for (int i = 0; i < 15; i++) ck(1'b0, 1'b0, 7'd0, 7'd2, 1'b1, 1'b0, "t6_hold");
        te_exp = 1'b1;
        ck(1'b0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, "t6_timeout");
        ck(1'b0, 1'b0, 7'd0, 7'd1, 1'b0, 1'b0, "t6_sticky_a");
        ck(1'b0, 1'b0, 7'd0, 7'd2, 1'b1, 1'b0, "t6_sticky_b");
        te_exp = 1'b0;
        step(1'b1, 1'b0, 1'b0, 7'd0, 7'd0, 1'b0, 1'b0, "t6_clear");
        ck(1'b0, 1'b0, 7'd0, 7'd1, 1'b0, 1'b0, "t6_fetch2");
        ck(1'b0, 1'b0, 7'd0, 7'd2, 1'b1, 1'b0, "t6_fwait2");
        for (int i = 0; i < 15; i++) ck(1'b0, 1'b0, 7'd0, 7'd2, 1'b1, 1'b0, "t6_hold2");
        ck(1'b1, 1'b0, 7'd0, 7'd3, 1'b0, 1'b0, "t6_moc_wins");
`else
        for (int i = 0; i < 20; i++) ck(1'b0, 1'b0, 7'd0, 7'd2, 1'b1, 1'b0, "t6_hold_forever");
        ck(1'b1, 1'b0, 7'd0, 7'd3, 1'b0, 1'b0, "t6_late_moc");
`endif
        ck(1'b0, 1'b0, 7'd0, 7'd1, 1'b0, 1'b0, "end_fetch");
        @(posedge clk);
        #2;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
